// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants for the RegisterFile write-port arbiter: default widths,
// the hard-wired zero register and the grant-source encoding.
package rf_wport_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_FIFO = 2'd2
    } gnt_src_e;

endpackage

// File: rtl/rf_result_fifo.sv
// Small circular FIFO holding MDU results until they win the write port.
// Ready depends only on the registered count, so a same-cycle pop never raises it.
module rf_result_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             do_pop;

    assign in_ready = (cnt < CNT_W'(DEPTH));
    assign push     = in_valid & in_ready;
    assign do_pop   = pop & (cnt != '0);
    assign head     = mem[rd_ptr];
    assign count    = cnt;

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the single RegisterFile write port between WB and queued MDU results,
// and tracks outstanding MDU destinations for decode hazard detection.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    input  logic              mdu_issue_valid,
    input  logic [ADDR_W-1:0] mdu_issue_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              hazard_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int unsigned ENTRY_W  = ADDR_W + DATA_W;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STV_W    = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [ENTRY_W-1:0]  fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_in_ready;
    logic                fifo_in_valid;
    logic                fifo_nonempty;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;

    logic                wb_req;
    logic                force_fifo;
    gnt_src_e            gnt;
    logic                pop;

    logic [STV_W-1:0]    starve_cnt;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_set;
    logic [NUM_REGS-1:0] busy_clr;
    logic [NUM_REGS-1:0] busy_next;

    // Results to x0 complete the handshake but are dropped here
    assign fifo_in_valid = mdu_valid & (mdu_addr != ADDR_W'(REG_ZERO));

    rf_result_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (fifo_in_valid),
        .in_ready (fifo_in_ready),
        .in_data  ({mdu_addr, mdu_data}),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign fifo_nonempty = (fifo_count != '0);
    assign head_addr     = fifo_head[DATA_W +: ADDR_W];
    assign head_data     = fifo_head[DATA_W-1:0];
    assign wb_req        = wb_valid & (wb_addr != ADDR_W'(REG_ZERO));
    assign force_fifo    = fifo_nonempty & (starve_cnt == STV_W'(STARVE_LIMIT));

    // Grant selection: WB first unless the FIFO has starved long enough
    always_comb begin
        gnt = GNT_NONE;
        if (force_fifo) begin
            gnt = GNT_FIFO;
        end else if (wb_req) begin
            gnt = GNT_WB;
        end else if (fifo_nonempty) begin
            gnt = GNT_FIFO;
        end
    end

    assign pop          = (gnt == GNT_FIFO);
    assign mdu_ready    = rst_n & fifo_in_ready;
    assign wb_stall     = rst_n & force_fifo & wb_req;
    assign hazard_stall = rst_n & (busy[rs1_addr] | busy[rs2_addr] | busy[rd_addr]);

    // Counts consecutive WB wins while MDU results wait
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!fifo_nonempty || gnt == GNT_FIFO) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_WB && starve_cnt != STV_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // Busy update; a same-cycle re-issue outranks the retiring write
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (mdu_issue_valid && mdu_issue_addr != ADDR_W'(REG_ZERO)) begin
            busy_set[mdu_issue_addr] = 1'b1;
        end
        if (pop) begin
            busy_clr[head_addr] = 1'b1;
        end
        busy_next    = (busy & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            case (gnt)
                GNT_WB: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= wb_addr;
                    rf_wdata <= wb_data;
                end
                GNT_FIFO: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= head_addr;
                    rf_wdata <= head_data;
                end
                default: begin
                    rf_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter; expected writes go through a scoreboard queue
// drained by an independent monitor, other outputs are checked inline.
module tb_rf_wport_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_issue_valid;
    logic [4:0]  mdu_issue_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        hazard_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [36:0] exp_q[$];
    int          checks;
    int          failures;

    rf_wport_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .wb_stall        (wb_stall),
        .mdu_valid       (mdu_valid),
        .mdu_ready       (mdu_ready),
        .mdu_addr        (mdu_addr),
        .mdu_data        (mdu_data),
        .mdu_issue_valid (mdu_issue_valid),
        .mdu_issue_addr  (mdu_issue_addr),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rd_addr         (rd_addr),
        .hazard_stall    (hazard_stall),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid        = 1'b0;
        wb_addr         = '0;
        wb_data         = '0;
        mdu_valid       = 1'b0;
        mdu_addr        = '0;
        mdu_data        = '0;
        mdu_issue_valid = 1'b0;
        mdu_issue_addr  = '0;
        rs1_addr        = '0;
        rs2_addr        = '0;
        rd_addr         = '0;
    endtask

    // Monitor: every write the DUT presents must match the next expected one
    always @(negedge clk) begin
        logic [36:0] e;
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got x%0d=0x%0h expected no write at %0t",
                         rf_waddr, rf_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(rf_waddr), 64'(e[36:32]));
                check("wr_data", 64'(rf_wdata), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        exp_rdy;
        clk      = 1'b0;
        rst_n    = 1'b0;
        checks   = 0;
        failures = 0;
        idle();

        // Reset with requests present: outputs stay quiet
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1;
        mdu_valid = 1'b1; mdu_addr = 5'd3;
        mdu_issue_valid = 1'b1; mdu_issue_addr = 5'd9; rs1_addr = 5'd9;
        tick();
        check("rst_mdu_ready", 64'(mdu_ready), 64'(0));
        check("rst_wb_stall", 64'(wb_stall), 64'(0));
        check("rst_hazard", 64'(hazard_stall), 64'(0));
        check("rst_rf_we", 64'(rf_we), 64'(0));
        idle();
        tick();
        rst_n = 1'b1;
        rs1_addr = 5'd9; rd_addr = 5'd9;
        #1;
        check("idle_rf_we", 64'(rf_we), 64'(0));
        check("idle_mdu_ready", 64'(mdu_ready), 64'(1));
        check("idle_hazard", 64'(hazard_stall), 64'(0));
        tick();
        check("idle_rf_we2", 64'(rf_we), 64'(0));

        // WB only, then WB to x0
        idle();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        #1;
        check("wb_only_stall", 64'(wb_stall), 64'(0));
        tick();
        check("wb_only_we", 64'(rf_we), 64'(1));
        wb_addr = 5'd0; wb_data = 32'h12345678;
        tick();
        check("wb_x0_no_write", 64'(rf_we), 64'(0));
        idle();
        tick();

        // Collision: x7 queued, WB to x3 every cycle; fifth contended cycle is forced
        d = 32'h300;
        for (int i = 0; i < 7; i++) begin
            wb_valid = 1'b1; wb_addr = 5'd3; wb_data = d;
            mdu_valid = (i == 0); mdu_addr = 5'd7; mdu_data = 32'h11;
            #1;
            check("coll_stall", 64'(wb_stall), 64'(i == 5));
            if (i == 5) begin
                expect_wr(5'd7, 32'h11);
            end else begin
                expect_wr(5'd3, d);
                d = d + 32'd1;
            end
            tick();
        end
        idle();
        tick();
        tick();

        // Backpressure: FIFO fills to 2, third result waits for a dequeue
        d = 32'h400;
        for (int i = 0; i < 9; i++) begin
            idle();
            if (i <= 6) begin
                wb_valid = 1'b1; wb_addr = 5'd4; wb_data = d;
                mdu_valid = 1'b1;
                mdu_addr = (i == 0) ? 5'd10 : (i == 1) ? 5'd11 : 5'd12;
                mdu_data = (i == 0) ? 32'hA1 : (i == 1) ? 32'hA2 : 32'hA3;
            end
            #1;
            if (i <= 6) begin
                exp_rdy = (i <= 1) || (i == 6);
                check("bp_ready", 64'(mdu_ready), 64'(exp_rdy));
                check("bp_stall", 64'(wb_stall), 64'(i == 5));
            end
            case (i)
                5:       expect_wr(5'd10, 32'hA1);
                7:       expect_wr(5'd11, 32'hA2);
                8:       expect_wr(5'd12, 32'hA3);
                default: begin expect_wr(5'd4, d); d = d + 32'd1; end
            endcase
            tick();
        end
        idle();
        tick();

        // Enqueue and dequeue together at count 1; result to x0 is swallowed
        mdu_valid = 1'b1; mdu_addr = 5'd13; mdu_data = 32'hD1;
        #1;
        check("cnt1_ready0", 64'(mdu_ready), 64'(1));
        tick();
        mdu_addr = 5'd14; mdu_data = 32'hD2;
        expect_wr(5'd13, 32'hD1);
        #1;
        check("cnt1_ready1", 64'(mdu_ready), 64'(1));
        tick();
        mdu_addr = 5'd0; mdu_data = 32'hBAD;
        expect_wr(5'd14, 32'hD2);
        #1;
        check("cnt1_kept", 64'(mdu_ready), 64'(1));
        tick();
        idle();
        tick();
        tick();
        check("x0_result_dropped", 64'(rf_we), 64'(0));

        // Scoreboard: issue x9, retire it, then re-issue on the retiring cycle
        mdu_issue_valid = 1'b1; mdu_issue_addr = 5'd9;
        tick();
        idle();
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hCAFE;
        rs1_addr = 5'd9; rs2_addr = 5'd4;
        #1;
        check("hz_rs1", 64'(hazard_stall), 64'(1));
        rs1_addr = 5'd0;
        #1;
        check("hz_rs2_clean", 64'(hazard_stall), 64'(0));
        rd_addr = 5'd9;
        #1;
        check("hz_rd", 64'(hazard_stall), 64'(1));
        tick();
        idle();
        rs1_addr = 5'd9;
        expect_wr(5'd9, 32'hCAFE);
        #1;
        check("hz_grant_cycle", 64'(hazard_stall), 64'(1));
        tick();
        check("hz_clear_we_cycle", 64'(hazard_stall), 64'(0));
        check("x9_read_we", 64'(rf_we), 64'(1));
        check("x9_read_data", 64'(rf_wdata), 64'(32'hCAFE));
        mdu_issue_valid = 1'b1; mdu_issue_addr = 5'd9;
        tick();
        mdu_issue_valid = 1'b0;
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hBEEF;
        tick();
        mdu_valid = 1'b0;
        mdu_issue_valid = 1'b1; mdu_issue_addr = 5'd9;
        expect_wr(5'd9, 32'hBEEF);
        tick();
        mdu_issue_valid = 1'b0;
        #1;
        check("hz_set_wins", 64'(hazard_stall), 64'(1));
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'hF00D;
        tick();
        mdu_valid = 1'b0;
        expect_wr(5'd9, 32'hF00D);
        tick();
        check("hz_final_clear", 64'(hazard_stall), 64'(0));
        idle();
        tick();

        // Reset mid-operation drops queued results and busy state
        wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h600;
        mdu_valid = 1'b1; mdu_addr = 5'd20; mdu_data = 32'hE1;
        mdu_issue_valid = 1'b1; mdu_issue_addr = 5'd20;
        expect_wr(5'd6, 32'h600);
        tick();
        mdu_issue_valid = 1'b0;
        wb_data = 32'h601; mdu_addr = 5'd21; mdu_data = 32'hE2;
        expect_wr(5'd6, 32'h601);
        tick();
        idle();
        rst_n = 1'b0;
        rs1_addr = 5'd20;
        #1;
        check("midrst_ready", 64'(mdu_ready), 64'(0));
        check("midrst_hazard", 64'(hazard_stall), 64'(0));
        tick();
        rst_n = 1'b1;
        #1;
        check("postrst_we", 64'(rf_we), 64'(0));
        check("postrst_ready", 64'(mdu_ready), 64'(1));
        check("postrst_hazard", 64'(hazard_stall), 64'(0));
        tick();
        check("postrst_we2", 64'(rf_we), 64'(0));
        tick();
        check("postrst_we3", 64'(rf_we), 64'(0));
        tick();

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
